mem_arbiter: RTL



---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the main-memory arbiter: FSM state encoding and
// owner codes reported on owner_o.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2
  } arb_state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Main-memory port arbiter between the I-cache and D-cache controllers.
// D-cache wins ties unless the I-cache has been passed over STARVE_LIMIT
// times in a row. The granted request is latched and held until the memory
// acks or the watchdog aborts the transaction.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 128,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_enable_i,
  input  logic              i_write_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic [LINE_W-1:0] i_data_i,
  output logic              i_ack_o,
  output logic [LINE_W-1:0] i_data_o,
  input  logic              d_enable_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [LINE_W-1:0] d_data_i,
  output logic              d_ack_o,
  output logic [LINE_W-1:0] d_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              busy_o,
  output logic              owner_o,
  output logic              timeout_o
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  // The wait counter only needs to reach TIMEOUT-1: that is the last cycle
  // in which an ack can still rescue the transaction.
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

  arb_state_t          state, state_nxt;
  logic                grant_i, grant_d, expire;
  logic [STARVE_W-1:0] starve_cnt;
  logic [WAIT_W-1:0]   wait_cnt;

  function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt);
    return (cnt >= STARVE_MAX) ? STARVE_MAX : cnt + STARVE_W'(1);
  endfunction

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  // Arbitration decision and transaction termination (ack or watchdog).
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    expire    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (d_enable_i && !(i_enable_i && (starve_cnt == STARVE_MAX))) begin
          grant_d   = 1'b1;
          state_nxt = ARB_GRANT_D;
        end else if (i_enable_i) begin
          grant_i   = 1'b1;
          state_nxt = ARB_GRANT_I;
        end
      end
      ARB_GRANT_I, ARB_GRANT_D: begin
        // An ack in the final watchdog cycle still completes normally.
        if (mem_ack_i) begin
          state_nxt = ARB_IDLE;
        end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
          expire    = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Capture the winning request; held constant for the whole transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_write_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
    end else if (grant_d) begin
      mem_write_o <= d_write_i;
      mem_addr_o  <= d_addr_i;
      mem_data_o  <= d_data_i;
    end else if (grant_i) begin
      mem_write_o <= i_write_i;
      mem_addr_o  <= i_addr_i;
      mem_data_o  <= i_data_i;
    end
  end

  // Count consecutive D grants that bypassed a waiting I-cache.
  always_ff @(posedge clock) begin
    if (reset || grant_i)  starve_cnt <= '0;
    else if (grant_d)      starve_cnt <= i_enable_i ? starve_inc(starve_cnt) : '0;
  end

  // Watchdog: cycles spent in a grant without an ack.
  always_ff @(posedge clock) begin
    if (reset || grant_i || grant_d)         wait_cnt <= '0;
    else if (busy_o && !mem_ack_i && !expire) wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  // Sticky abort flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset)       timeout_o <= 1'b0;
    else if (expire) timeout_o <= 1'b1;
  end

  assign busy_o       = (state != ARB_IDLE);
  assign mem_enable_o = busy_o;
  assign owner_o      = (state == ARB_GRANT_D) ? OWNER_D : OWNER_I;
  assign i_ack_o      = (state == ARB_GRANT_I) && mem_ack_i;
  assign d_ack_o      = (state == ARB_GRANT_D) && mem_ack_i;
  assign i_data_o     = mem_data_i;
  assign d_data_o     = mem_data_i;

endmodule
